// File: rtl/mac_sched.sv
// Round-robin arbiter that locks one shared 8x8 multiply-accumulate datapath to a single requester
// per dot-product job and returns the final accumulator value tagged with the owner's id.
module mac_sched #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DP_LAT    = 1,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [8*NREQ-1:0]        req_a,
   input  logic [8*NREQ-1:0]        req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic                     dp_clr,
   output logic                     dp_en,
   output logic [7:0]               dp_a,
   output logic [7:0]               dp_b,
   input  logic [16:0]              dp_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [16:0]              rsp_data,
   output logic                     rsp_ovf,
   output logic                     rsp_trunc
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = 8;
   localparam int unsigned LW  = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
   localparam int unsigned DW  = 17;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DRAIN,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  gid_q, gid_d;
   logic [IDW-1:0]  rr_q, rr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   lat_q, lat_d;
   logic            ovf_q, ovf_d;
   logic            trunc_q, trunc_d;
   logic            rsp_valid_d;
   logic [IDW-1:0]  rsp_id_d;
   logic [DW-1:0]   rsp_data_d;
   logic            rsp_ovf_d;
   logic            rsp_trunc_d;
   logic            found;
   logic [IDW-1:0]  cand;

   // State and job-context registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         gid_q     <= '0;
         rr_q      <= '0;
         cnt_q     <= '0;
         lat_q     <= '0;
         ovf_q     <= 1'b0;
         trunc_q   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_ovf   <= 1'b0;
         rsp_trunc <= 1'b0;
      end else begin
         state_q   <= state_d;
         gid_q     <= gid_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         lat_q     <= lat_d;
         ovf_q     <= ovf_d;
         trunc_q   <= trunc_d;
         rsp_valid <= rsp_valid_d;
         rsp_id    <= rsp_id_d;
         rsp_data  <= rsp_data_d;
         rsp_ovf   <= rsp_ovf_d;
         rsp_trunc <= rsp_trunc_d;
      end
   end

   // Next-state, grant and datapath steering
   always_comb begin
      state_d     = state_q;
      gid_d       = gid_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      lat_d       = lat_q;
      ovf_d       = ovf_q;
      trunc_d     = trunc_q;
      rsp_valid_d = rsp_valid;
      rsp_id_d    = rsp_id;
      rsp_data_d  = rsp_data;
      rsp_ovf_d   = rsp_ovf;
      rsp_trunc_d = rsp_trunc;
      req_ready   = '0;
      dp_clr      = 1'b0;
      dp_en       = 1'b0;
      dp_a        = '0;
      dp_b        = '0;
      found       = 1'b0;
      cand        = '0;

      case (state_q)
         S_IDLE: begin
            // first valid requester at or after the round-robin pointer
            for (int k = 0; k < int'(NREQ); k++) begin
               cand = IDW'((int'(rr_q) + k) % int'(NREQ));
               if (!found && req_valid[cand]) begin
                  found = 1'b1;
                  gid_d = cand;
               end
            end
            if (found) state_d = S_CLR;
         end
         S_CLR: begin
            dp_clr  = 1'b1;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            trunc_d = 1'b0;
            state_d = S_RUN;
         end
         S_RUN: begin
            req_ready[gid_q] = 1'b1;
            ovf_d            = ovf_q | dp_result[16];
            if (req_valid[gid_q]) begin
               dp_en = 1'b1;
               dp_a  = req_a[{gid_q, 3'b000} +: 8];
               dp_b  = req_b[{gid_q, 3'b000} +: 8];
               cnt_d = cnt_q + CW'(1);
               if (req_last[gid_q] || (cnt_q == CW'(MAX_BEATS - 1))) begin
                  trunc_d = ~req_last[gid_q];
                  lat_d   = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            ovf_d = ovf_q | dp_result[16];
            if (lat_q == LW'(DP_LAT - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = gid_q;
               rsp_data_d  = dp_result;
               rsp_ovf_d   = ovf_q | dp_result[16];
               rsp_trunc_d = trunc_q;
               state_d     = S_RESP;
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rr_d        = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mac_sched.sv
// Scoreboard bench for mac_sched: per-requester beat drivers, a behavioural accumulator datapath,
// and a response monitor that pops hand-computed expectations on every rsp handshake.
module tb_mac_sched;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid, req_last, req_ready;
   logic [8*NREQ-1:0] req_a, req_b;
   logic              dp_clr, dp_en;
   logic [7:0]        dp_a, dp_b;
   logic [16:0]       dp_result;
   logic              rsp_valid, rsp_ready;
   logic [1:0]        rsp_id;
   logic [16:0]       rsp_data;
   logic              rsp_ovf, rsp_trunc;

   always #5 clk = ~clk;

   mac_sched #(.NREQ(NREQ), .DP_LAT(1), .MAX_BEATS(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_last(req_last), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready),
      .dp_clr(dp_clr), .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .rsp_trunc(rsp_trunc)
   );

   // external datapath: 17-bit wrapping accumulator, one cycle latency
   logic [16:0] acc = '0;
   always @(posedge clk) begin
      if (dp_clr)     acc <= '0;
      else if (dp_en) acc <= acc + (17'(dp_a) * 17'(dp_b));
   end
   assign dp_result = acc;

   typedef struct packed {logic [1:0] id; logic [16:0] data; logic ovf; logic trunc;} rsp_t;
   typedef struct packed {logic [7:0] a; logic [7:0] b; logic last;} beat_t;

   rsp_t  sb[$];
   beat_t mem [NREQ][32];
   int    head [NREQ] = '{0, 0, 0, 0};
   int    tail [NREQ] = '{0, 0, 0, 0};
   logic [NREQ-1:0] hs;
   int    tests = 0;
   int    fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic beat(input int r, input logic [7:0] a, input logic [7:0] b, input logic last);
      mem[r][tail[r]] = {a, b, last};
      tail[r]++;
   endtask

   task automatic expect_rsp(input int id, input int data, input logic ovf, input logic trunc);
      sb.push_back({2'(id), 17'(data), ovf, trunc});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drained(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d responses outstanding after %0d cycles, required 0", name, sb.size(), n);
      end
      tick();
      tick();
   endtask

   // beat drivers: present the head beat of each requester, advance on accepted handshake
   initial begin
      req_valid = '0; req_last = '0; req_a = '0; req_b = '0;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) head[i]++;
            if (head[i] < tail[i]) begin
               req_valid[i]       = 1'b1;
               req_last[i]        = mem[i][head[i]].last;
               req_a[8*i +: 8]    = mem[i][head[i]].a;
               req_b[8*i +: 8]    = mem[i][head[i]].b;
            end else begin
               req_valid[i]       = 1'b0;
               req_last[i]        = 1'b0;
               req_a[8*i +: 8]    = '0;
               req_b[8*i +: 8]    = '0;
            end
         end
      end
   end

   // response monitor
   initial begin
      rsp_t got, exp;
      forever begin
         @(negedge clk);
         if (reset && rsp_valid && rsp_ready) begin
            got = {rsp_id, rsp_data, rsp_ovf, rsp_trunc};
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL rsp_unexpected: got id=%0d data=%0d, required no response", rsp_id, rsp_data);
            end else begin
               exp = sb.pop_front();
               if (got !== exp) begin
                  fails++;
                  $display("FAIL rsp: got id=%0d data=%0d ovf=%0d trunc=%0d, required id=%0d data=%0d ovf=%0d trunc=%0d",
                           got.id, got.data, got.ovf, got.trunc, exp.id, exp.data, exp.ovf, exp.trunc);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      reset     = 1'b0;
      rsp_ready = 1'b1;

      // fairness: every requester holds two one-beat jobs
      for (int i = 0; i < NREQ; i++) begin
         beat(i, 8'(i + 1), 8'd2, 1'b1);
         beat(i, 8'(i + 1), 8'd3, 1'b1);
      end
      for (int i = 0; i < NREQ; i++) expect_rsp(i, 2 * (i + 1), 1'b0, 1'b0);
      for (int i = 0; i < NREQ; i++) expect_rsp(i, 3 * (i + 1), 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_dp_clr", 32'(dp_clr), 32'd0);
      check("reset_dp_en", 32'(dp_en), 32'd0);
      check("reset_dp_a", 32'(dp_a), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", 32'(rsp_data), 32'd0);
      reset = 1'b1;
      wait_drained("fairness");

      // single two-beat job
      beat(0, 8'd3, 8'd4, 1'b0);
      beat(0, 8'd5, 8'd6, 1'b1);
      expect_rsp(0, 42, 1'b0, 1'b0);
      wait_drained("single");

      // overflow: 3 x 255*255 wraps at 2^17
      beat(1, 8'd255, 8'd255, 1'b0);
      beat(1, 8'd255, 8'd255, 1'b0);
      beat(1, 8'd255, 8'd255, 1'b1);
      expect_rsp(1, 64003, 1'b1, 1'b0);
      wait_drained("overflow");

      // truncation at 16 beats, remainder becomes its own job
      for (int i = 0; i < 16; i++) beat(2, 8'd1, 8'd1, 1'b0);
      beat(2, 8'd1, 8'd1, 1'b1);
      expect_rsp(2, 16, 1'b0, 1'b1);
      expect_rsp(2, 1, 1'b0, 1'b0);
      wait_drained("truncation");

      // backpressure with req3 arriving during RESP
      rsp_ready = 1'b0;
      beat(0, 8'd7, 8'd7, 1'b1);
      expect_rsp(0, 49, 1'b0, 1'b0);
      expect_rsp(3, 10, 1'b0, 1'b0);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_rsp_valid_arrives", 32'(rsp_valid), 32'd1);
      beat(3, 8'd2, 8'd5, 1'b1);
      for (int c = 0; c < 10; c++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_id", 32'(rsp_id), 32'd0);
         check("bp_rsp_data", 32'(rsp_data), 32'd49);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      tick();
      rsp_ready = 1'b1;
      wait_drained("backpressure");

      // reset in RUN after two accepted beats; the last beat forms a fresh job
      beat(0, 8'd1, 8'd1, 1'b0);
      beat(0, 8'd2, 8'd2, 1'b0);
      beat(0, 8'd3, 8'd3, 1'b1);
      n = 0;
      while (head[0] != tail[0] - 1 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("rst_two_beats_taken", 32'(tail[0] - head[0]), 32'd1);
      reset = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_dp_en", 32'(dp_en), 32'd0);
      check("rst_dp_clr", 32'(dp_clr), 32'd0);
      check("rst_dp_a", 32'(dp_a), 32'd0);
      check("rst_dp_b", 32'(dp_b), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      expect_rsp(0, 9, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_drained("reset_recovery");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
